// File: rtl/bill_pkg.sv
// Shared definitions for the billing lane arbiter: item codes, default
// prices, FSM state encoding and the item-to-price lookup.
package bill_pkg;

    typedef enum logic [1:0] {
        ITEM_NONE = 2'b00,
        ITEM_P1   = 2'b01,
        ITEM_P2   = 2'b10,
        ITEM_P3   = 2'b11
    } item_e;

    localparam int PRICE_P1_DEF = 2;
    localparam int PRICE_P2_DEF = 5;
    localparam int PRICE_P3_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Price for one scanned item; the price table is passed in so the
    // top level can override the defaults through its parameters.
    function automatic int price_of(input item_e code, input int p1, input int p2, input int p3);
        int price;
        case (code)
            ITEM_NONE: price = 0;
            ITEM_P1:   price = p1;
            ITEM_P2:   price = p2;
            ITEM_P3:   price = p3;
            default:   price = 0;
        endcase
        return price;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting cart at or
// above the pointer, wrapping around, as both a one-hot vector and an index.
module rr_arbiter #(
    parameter int NUM_CARTS = 4
) (
    input  logic [NUM_CARTS-1:0]         req_i,
    input  logic [$clog2(NUM_CARTS)-1:0] ptr_i,
    output logic [NUM_CARTS-1:0]         grant_o,
    output logic [$clog2(NUM_CARTS)-1:0] idx_o,
    output logic                         any_o
);

    localparam int IDX_W = $clog2(NUM_CARTS);

    // Walk the request vector starting at the pointer; the first hit wins.
    always_comb begin
        int  j;
        logic hit;
        j       = 0;
        hit     = 1'b0;
        grant_o = {NUM_CARTS{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        any_o   = 1'b0;
        for (int k = 0; k < NUM_CARTS; k++) begin
            j          = (int'(ptr_i) + k) % NUM_CARTS;
            hit        = !any_o && req_i[j];
            grant_o[j] = grant_o[j] | hit;
            idx_o      = hit ? IDX_W'(j) : idx_o;
            any_o      = any_o | hit;
        end
    end

endmodule

// File: rtl/bill_lane_arbiter.sv
// Billing lane arbiter: one shared saturating adder serves NUM_CARTS cart
// scanners in round-robin order, keeping a running total per cart and
// issuing a one-cycle bill when a cart asks to pay.
module bill_lane_arbiter
    import bill_pkg::*;
#(
    parameter int NUM_CARTS = 4,
    parameter int COST_W    = 8,
    parameter int PRICE_P1  = PRICE_P1_DEF,
    parameter int PRICE_P2  = PRICE_P2_DEF,
    parameter int PRICE_P3  = PRICE_P3_DEF
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_CARTS-1:0]          Req,
    input  logic [NUM_CARTS-1:0]          PayReq,
    input  logic [2*NUM_CARTS-1:0]        Item,
    output logic [NUM_CARTS-1:0]          Grant,
    output logic [COST_W*NUM_CARTS-1:0]   Totals,
    output logic [NUM_CARTS-1:0]          Overflow,
    output logic                          BillValid,
    output logic [$clog2(NUM_CARTS)-1:0]  BillCart,
    output logic [COST_W-1:0]             BillTotal
);

    localparam int IDX_W = $clog2(NUM_CARTS);

    state_e                               state_q;
    logic [IDX_W-1:0]                     ptr_q;
    logic [IDX_W-1:0]                     win_q;
    logic [NUM_CARTS-1:0]                 grant_q;
    logic [NUM_CARTS-1:0][COST_W-1:0]     totals_q;
    logic [NUM_CARTS-1:0]                 ovf_q;
    logic                                 bill_valid_q;
    logic [IDX_W-1:0]                     bill_cart_q;
    logic [COST_W-1:0]                    bill_total_q;

    logic [NUM_CARTS-1:0]                 any_req_s;
    logic [NUM_CARTS-1:0]                 arb_grant_s;
    logic [IDX_W-1:0]                     arb_idx_s;
    logic                                 arb_any_s;
    item_e                                item_s;
    logic [COST_W:0]                      price_s;
    logic [COST_W:0]                      sum_s;
    logic [COST_W-1:0]                    sat_sum_s;
    logic [IDX_W-1:0]                     ptr_next_s;

    assign any_req_s = Req | PayReq;

    rr_arbiter #(
        .NUM_CARTS (NUM_CARTS)
    ) u_rr_arbiter (
        .req_i   (any_req_s),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .any_o   (arb_any_s)
    );

    // Shared adder: price of the winner's item added to its total with one
    // carry bit; the carry both saturates the result and flags overflow.
    always_comb begin
        item_s     = item_e'(Item[{win_q, 1'b0} +: 2]);
        price_s    = (COST_W+1)'(price_of(item_s, PRICE_P1, PRICE_P2, PRICE_P3));
        sum_s      = {1'b0, totals_q[win_q]} + price_s;
        sat_sum_s  = sum_s[COST_W] ? {COST_W{1'b1}} : sum_s[COST_W-1:0];
        ptr_next_s = (win_q == IDX_W'(NUM_CARTS - 1)) ? {IDX_W{1'b0}} : win_q + IDX_W'(1);
    end

    // Service FSM: pick a cart in IDLE, add or bill for exactly one cycle in
    // SERVE, then hold the grant until that cart releases its keys.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {IDX_W{1'b0}};
            win_q        <= {IDX_W{1'b0}};
            grant_q      <= {NUM_CARTS{1'b0}};
            totals_q     <= '0;
            ovf_q        <= {NUM_CARTS{1'b0}};
            bill_valid_q <= 1'b0;
            bill_cart_q  <= {IDX_W{1'b0}};
            bill_total_q <= {COST_W{1'b0}};
        end else begin
            bill_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        win_q   <= arb_idx_s;
                        grant_q <= arb_grant_s;
                        state_q <= ST_SERVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (PayReq[win_q]) begin
                        // Checkout wins over any item scanned on the same press.
                        bill_valid_q     <= 1'b1;
                        bill_cart_q      <= win_q;
                        bill_total_q     <= totals_q[win_q];
                        totals_q[win_q]  <= {COST_W{1'b0}};
                        ovf_q[win_q]     <= 1'b0;
                    end else begin
                        totals_q[win_q]  <= sat_sum_s;
                        ovf_q[win_q]     <= ovf_q[win_q] | sum_s[COST_W];
                    end
                    ptr_q   <= ptr_next_s;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Waiting for key release gives one service per press.
                    if (!Req[win_q] && !PayReq[win_q]) begin
                        grant_q <= {NUM_CARTS{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    grant_q <= {NUM_CARTS{1'b0}};
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Grant     = grant_q;
    assign Totals    = totals_q;
    assign Overflow  = ovf_q;
    assign BillValid = bill_valid_q;
    assign BillCart  = bill_cart_q;
    assign BillTotal = bill_total_q;

endmodule

// File: tb/tb_bill_lane_arbiter.sv
// Self-checking bench for bill_lane_arbiter: directed scenarios plus random
// traffic against a transaction-level model, with a scoreboard monitor.
module tb_bill_lane_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              Reset;
    logic [N-1:0]      Req;
    logic [N-1:0]      PayReq;
    logic [2*N-1:0]    Item;
    logic [N-1:0]      Grant;
    logic [CW*N-1:0]   Totals;
    logic [N-1:0]      Overflow;
    logic              BillValid;
    logic [$clog2(N)-1:0] BillCart;
    logic [CW-1:0]     BillTotal;

    bill_lane_arbiter #(.NUM_CARTS(N), .COST_W(CW)) dut (
        .Clk(clk), .Reset(Reset), .Req(Req), .PayReq(PayReq), .Item(Item),
        .Grant(Grant), .Totals(Totals), .Overflow(Overflow),
        .BillValid(BillValid), .BillCart(BillCart), .BillTotal(BillTotal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int bills_seen = 0;

    // reference model state
    int mtot[N];
    bit movf[N];
    int mptr;

    // scoreboard queues
    int q_grant[$];
    int q_bcart[$];
    int q_btot[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int price(input logic [1:0] c);
        case (c)
            2'b01:   return 2;
            2'b10:   return 5;
            2'b11:   return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // monitor: compare every new grant and every bill against the scoreboard
    logic [N-1:0] prev_grant = '0;
    logic         prev_bv    = 1'b0;
    always @(negedge clk) begin
        if (Grant != '0 && prev_grant == '0) begin
            if (q_grant.size() == 0) chk("unexpected_grant", int'(Grant), 0);
            else chk("grant_winner", int'(Grant), 1 << q_grant.pop_front());
        end
        if (BillValid) begin
            bills_seen++;
            chk("bill_not_back_to_back", int'(prev_bv), 0);
            if (q_bcart.size() == 0) chk("unexpected_bill", int'(BillValid), 0);
            else begin
                chk("bill_cart", int'(BillCart), q_bcart.pop_front());
                chk("bill_total", int'(BillTotal), q_btot.pop_front());
            end
        end
        prev_grant <= Grant;
        prev_bv    <= BillValid;
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mtot[i] = 0;
            movf[i] = 1'b0;
        end
        mptr = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_total"}, int'(Totals[i*CW +: CW]), mtot[i]);
            chk({tag, "_ovf"}, int'(Overflow[i]), int'(movf[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1; Req = '0; PayReq = '0; Item = '0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        model_clear();
        chk("rst_grant", int'(Grant), 0);
        chk("rst_billvalid", int'(BillValid), 0);
        chk("rst_billcart", int'(BillCart), 0);
        chk("rst_billtotal", int'(BillTotal), 0);
        check_all("rst");
    endtask

    // wait (bounded) for the grant to appear; returns observed grant
    task automatic wait_grant(input int w, output logic [N-1:0] g);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (Grant != '0) got = 1'b1;
        end
        if (!got) chk("grant_timeout", int'(Grant), 1 << w);
        g = Grant;
    endtask

    // one press: drive keys, predict the result, hold, release, check
    task automatic service(input logic [N-1:0] r, input logic [N-1:0] p,
                           input logic [2*N-1:0] it, input int hold,
                           output logic [N-1:0] g);
        int w;
        int s;
        g = '0;
        if ((r | p) == '0) begin
            Req = r; PayReq = p; Item = it;
            repeat (2) @(negedge clk);
            chk("idle_no_grant", int'(Grant), 0);
            return;
        end
        w = pick(r | p);
        q_grant.push_back(w);
        if (p[w]) begin
            q_bcart.push_back(w);
            q_btot.push_back(mtot[w]);
            mtot[w] = 0;
            movf[w] = 1'b0;
        end else begin
            s = mtot[w] + price(it[2*w +: 2]);
            if (s > MAXV) begin
                mtot[w] = MAXV;
                movf[w] = 1'b1;
            end else begin
                mtot[w] = s;
            end
        end
        mptr = (w + 1) % N;
        Req = r; PayReq = p; Item = it;
        wait_grant(w, g);
        @(negedge clk);
        chk("grant_in_serve", int'(Grant), 1 << w);
        check_all("serve");
        for (int h = 0; h < hold; h++) begin
            Item = 8'($urandom);
            @(negedge clk);
            chk("grant_held", int'(Grant), 1 << w);
        end
        check_all("hold");
        Req = '0; PayReq = '0;
        @(negedge clk);
        chk("grant_release", int'(Grant), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] cur;
        int w;
        int b0;
        Reset = 1'b1; Req = '0; PayReq = '0; Item = '0;

        // 1: single short press on cart 0, item 01
        do_reset();
        service(4'b0001, 4'b0000, 8'b0000_0001, 0, g);
        chk("t1_total0", int'(Totals[0 +: CW]), 2);
        chk("t1_no_bill", bills_seen, 0);

        // 2: cart 1 key held for 20 cycles, item 11 -> single add
        do_reset();
        service(4'b0010, 4'b0000, 8'b0000_1100, 18, g);
        chk("t2_total1", int'(Totals[CW +: CW]), 10);

        // 3: all carts held, release each on grant -> order 0,1,2,3
        do_reset();
        cur = 4'b1111;
        Req = cur; Item = 8'b1010_1010;
        for (int n = 0; n < N; n++) begin
            w = pick(cur);
            q_grant.push_back(w);
            mtot[w] = mtot[w] + 5;
            mptr = (w + 1) % N;
            wait_grant(w, g);
            chk("t3_rr_order", int'(g), 1 << n);
            @(negedge clk);
            cur[w] = 1'b0;
            Req = cur;
            @(negedge clk);
            chk("t3_release", int'(Grant), 0);
        end
        for (int i = 0; i < N; i++) chk("t3_total", int'(Totals[i*CW +: CW]), 5);
        service(4'b1111, 4'b0000, 8'b1010_1010, 0, g);
        chk("t3_next_winner", int'(g), 1);

        // 4: cart 2 saturates after 26 adds of 10, then pays 255
        do_reset();
        for (int n = 0; n < 26; n++) service(4'b0100, 4'b0000, 8'b0011_0000, 0, g);
        chk("t4_sat_total", int'(Totals[2*CW +: CW]), 255);
        chk("t4_sat_ovf", int'(Overflow[2]), 1);
        b0 = bills_seen;
        service(4'b0000, 4'b0100, 8'b0011_0000, 0, g);
        chk("t4_one_bill", bills_seen - b0, 1);
        chk("t4_cleared_total", int'(Totals[2*CW +: CW]), 0);
        chk("t4_cleared_ovf", int'(Overflow[2]), 0);

        // 5: Req and PayReq together on cart 3 -> bill only, item ignored
        do_reset();
        service(4'b1000, 4'b0000, 8'b1000_0000, 0, g);
        service(4'b1000, 4'b0000, 8'b0100_0000, 0, g);
        chk("t5_pre_total", int'(Totals[3*CW +: CW]), 7);
        b0 = bills_seen;
        service(4'b1000, 4'b1000, 8'b1100_0000, 0, g);
        chk("t5_one_bill", bills_seen - b0, 1);
        chk("t5_total3", int'(Totals[3*CW +: CW]), 0);

        // 6: reset during SERVE wins over the pending add
        do_reset();
        service(4'b0001, 4'b0000, 8'b0000_0011, 0, g);
        q_grant.push_back(pick(4'b0010));
        Req = 4'b0010; Item = 8'b0000_1100;
        wait_grant(1, g);
        Reset = 1'b1;
        @(negedge clk);
        chk("t6_grant", int'(Grant), 0);
        chk("t6_billvalid", int'(BillValid), 0);
        for (int i = 0; i < N; i++) chk("t6_total", int'(Totals[i*CW +: CW]), 0);
        Reset = 1'b0; Req = '0;
        model_clear();
        @(negedge clk);
        chk("t6_idle", int'(Grant), 0);
        service(4'b0010, 4'b0000, 8'b0000_0100, 0, g);

        // random traffic
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [N-1:0] r;
            logic [N-1:0] p;
            r = 4'($urandom);
            p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            service(r, p, 8'($urandom), $urandom_range(0, 3), g);
        end

        repeat (2) @(negedge clk);
        chk("sb_grant_empty", q_grant.size(), 0);
        chk("sb_bill_empty", q_bcart.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
